// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C command sequencer slice.
//   seq_state_t     : sequencer FSM state encoding
//   I2C_ADDR_WIDTH  : default I2C device address width
//   I2C_DATA_WIDTH  : default data byte width
// -----------------------------------------------------------------------------
package i2c_pkg;

  localparam int I2C_ADDR_WIDTH = 7;
  localparam int I2C_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    SEQ_IDLE    = 2'd0,
    SEQ_ISSUE   = 2'd1,
    SEQ_BUSY    = 2'd2,
    SEQ_CAPTURE = 2'd3
  } seq_state_t;

endpackage : i2c_pkg

// File: rtl/i2c_sync_fifo.sv
// -----------------------------------------------------------------------------
// i2c_sync_fifo
// Single-clock FIFO with occupancy output. Reads come from stored entries
// only (no write-to-read bypass). Pushes while full and pops while empty are
// ignored; a simultaneous push and pop leaves the level unchanged.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   push_i    : write request, data_i written when not full
//   pop_i     : read request, head advances when not empty
//   data_o    : current head entry (valid while empty_o is low)
//   level_o   : number of stored entries, 0..DEPTH
//   full_o    : level_o == DEPTH
//   empty_o   : level_o == 0
// DEPTH must be a power of two and >= 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module i2c_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("i2c_sync_fifo: DEPTH must be a power of two and >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // NOTE: the storage array is deliberately not reset; pointers and level
  // alone decide which entries are valid, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule : i2c_sync_fifo

// File: rtl/i2c_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_cmd_sequencer
// Queues I2C commands {addr, rw, data} and issues them one at a time, in
// order, to a byte-level I2C master controller. Read results are returned on
// a valid/ready response port.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           : command push handshake
//   cmd_addr/cmd_rw/cmd_data      : command fields (rw: 0=write, 1=read)
//   rsp_valid/rsp_ready/rsp_data  : read-response handshake
//   m_address/m_data_in/m_rw      : registered command to the master
//   m_enable                      : start strobe, held until master drops m_ready
//   m_ready/m_data_out            : master status and read data
//   fifo_level                    : queued command count
//   busy                          : transaction in flight or commands queued
//   err_timeout                   : sticky transaction-timeout flag
// Configuration: define I2C_SEQ_TIMEOUT_EN to bound each transaction to
// TIMEOUT_CYCLES clocks in ISSUE/BUSY; otherwise err_timeout is tied low and
// the FSM waits on the master indefinitely.
// -----------------------------------------------------------------------------
module i2c_cmd_sequencer
  import i2c_pkg::*;
#(
  parameter int ADDR_WIDTH     = I2C_ADDR_WIDTH,
  parameter int DATA_WIDTH     = I2C_DATA_WIDTH,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [ADDR_WIDTH-1:0]           cmd_addr,
  input  logic                            cmd_rw,
  input  logic [DATA_WIDTH-1:0]           cmd_data,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic [ADDR_WIDTH-1:0]           m_address,
  output logic [DATA_WIDTH-1:0]           m_data_in,
  output logic                            m_rw,
  output logic                            m_enable,
  input  logic                            m_ready,
  input  logic [DATA_WIDTH-1:0]           m_data_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            busy,
  output logic                            err_timeout
);

  localparam int CMD_W = ADDR_WIDTH + 1 + DATA_WIDTH;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("i2c_cmd_sequencer: TIMEOUT_CYCLES must be >= 2");
  end

  seq_state_t            state_q;
  logic [ADDR_WIDTH-1:0] m_address_q;
  logic [DATA_WIDTH-1:0] m_data_in_q;
  logic                  m_rw_q;
  logic                  m_enable_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  logic [CMD_W-1:0]      fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic                  rsp_slot_free;

  // Pop only when the master is idle so the popped command issues at once.
  assign fifo_pop      = (state_q == SEQ_IDLE) && !fifo_empty && m_ready;
  // The response register can take new data if empty or draining this cycle.
  assign rsp_slot_free = !rsp_valid_q || rsp_ready;

  i2c_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid),
    .data_i  ({cmd_addr, cmd_rw, cmd_data}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  logic [TIMER_W-1:0] timer_q;
  logic               err_timeout_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SEQ_IDLE;
      m_address_q   <= '0;
      m_data_in_q   <= '0;
      m_rw_q        <= 1'b0;
      m_enable_q    <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
      timer_q       <= '0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments resolve last-write-wins, so a capture
      // in the case below overrides this retire, and the timeout block
      // further down overrides any normal transition taken in the same cycle.
      if (rsp_valid_q && rsp_ready) rsp_valid_q <= 1'b0;

      case (state_q)
        SEQ_IDLE: begin
          if (fifo_pop) begin
            {m_address_q, m_rw_q, m_data_in_q} <= fifo_head;
            m_enable_q <= 1'b1;
            state_q    <= SEQ_ISSUE;
`ifdef I2C_SEQ_TIMEOUT_EN
            timer_q    <= '0;
`endif
          end
        end
        SEQ_ISSUE: begin
          // Master signals acceptance by dropping m_ready.
          if (!m_ready) begin
            m_enable_q <= 1'b0;
            state_q    <= SEQ_BUSY;
          end
        end
        SEQ_BUSY: begin
          if (m_ready) state_q <= m_rw_q ? SEQ_CAPTURE : SEQ_IDLE;
        end
        SEQ_CAPTURE: begin
          if (rsp_slot_free) begin
            rsp_data_q  <= m_data_out;
            rsp_valid_q <= 1'b1;
            state_q     <= SEQ_IDLE;
          end
        end
        default: state_q <= SEQ_IDLE;
      endcase

`ifdef I2C_SEQ_TIMEOUT_EN
      if ((state_q == SEQ_ISSUE) || (state_q == SEQ_BUSY)) begin
        if (timer_q == TIMER_LAST) begin
          m_enable_q    <= 1'b0;
          err_timeout_q <= 1'b1;
          state_q       <= SEQ_IDLE;
        end else begin
          timer_q <= timer_q + TIMER_W'(1);
        end
      end
`endif
    end
  end

  assign m_address = m_address_q;
  assign m_data_in = m_data_in_q;
  assign m_rw      = m_rw_q;
  assign m_enable  = m_enable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign cmd_ready = !fifo_full;
  assign busy      = (state_q != SEQ_IDLE) || !fifo_empty;

`ifdef I2C_SEQ_TIMEOUT_EN
  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule : i2c_cmd_sequencer

// File: tb/tb_i2c_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_i2c_cmd_sequencer
// Directed bench for i2c_cmd_sequencer with a behavioural I2C master model.
// Issued commands are compared in order against a queue filled at push time;
// read responses are compared against a queue filled when the read is pushed.
// The timeout scenario runs only when I2C_SEQ_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_i2c_cmd_sequencer;

  localparam int AW          = 7;
  localparam int DW          = 8;
  localparam int DEPTH       = 4;
  localparam int LW          = $clog2(DEPTH + 1);
  localparam int TO          = 64;
  localparam int ACCEPT_DLY  = 3;
  localparam int BUSY_CYCLES = 40;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          cmd_rw;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] m_address;
  logic [DW-1:0] m_data_in;
  logic          m_rw;
  logic          m_enable;
  logic          m_ready;
  logic [DW-1:0] m_data_out;
  logic [LW-1:0] fifo_level;
  logic          busy;
  logic          err_timeout;

  int n_checks = 0;
  int n_errors = 0;

  logic [AW+DW:0] exp_cmd[$];
  logic [DW-1:0]  exp_rsp[$];
  logic [DW-1:0]  rd_data_q[$];

  bit model_hold  = 1'b0;
  bit model_stuck = 1'b0;
  bit acc;
  int n;

  i2c_cmd_sequencer #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_rw      (cmd_rw),
    .cmd_data    (cmd_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .m_address   (m_address),
    .m_data_in   (m_data_in),
    .m_rw        (m_rw),
    .m_enable    (m_enable),
    .m_ready     (m_ready),
    .m_data_out  (m_data_out),
    .fifo_level  (fifo_level),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_enable"},    m_enable,    0);
    check({tag, "_m_address"},   m_address,   0);
    check({tag, "_m_rw"},        m_rw,        0);
    check({tag, "_m_data_in"},   m_data_in,   0);
    check({tag, "_rsp_valid"},   rsp_valid,   0);
    check({tag, "_rsp_data"},    rsp_data,    0);
    check({tag, "_fifo_level"},  fifo_level,  0);
    check({tag, "_busy"},        busy,        0);
    check({tag, "_err_timeout"}, err_timeout, 0);
    check({tag, "_cmd_ready"},   cmd_ready,   1);
  endtask

  // Offer one command for a single clock; acc reports whether it was taken.
  task automatic push_cmd(input logic [AW-1:0] a, input logic rw,
                          input logic [DW-1:0] d, output bit accepted);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_rw    = rw;
    cmd_data  = d;
    #1 accepted = cmd_ready;
    if (accepted) exp_cmd.push_back({a, rw, d});
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_idle_in_time"}, busy, 0);
  endtask

  task automatic wait_rsp(input int budget, input string tag);
    int k = 0;
    while (rsp_valid !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_rsp_in_time"}, rsp_valid, 1);
  endtask

  // Master model: accepts ACCEPT_DLY cycles after m_enable is seen, stays
  // busy BUSY_CYCLES cycles (or while stuck), then reports ready again.
  task automatic serve_txn();
    logic [AW+DW:0] got;
    logic           rw;
    bit             was_stuck;
    got       = {m_address, m_rw, m_data_in};
    rw        = m_rw;
    was_stuck = model_stuck;
    check("cmd_expected", exp_cmd.size() != 0, 1);
    if (exp_cmd.size() != 0) check("cmd_order", got, exp_cmd.pop_front());
    for (int i = 0; i < ACCEPT_DLY; i++) begin
      @(negedge clk); #1;
      if (rst) begin m_ready = 1'b1; return; end
      check("m_enable_held", m_enable, 1);
      check("m_cmd_stable", {m_address, m_rw, m_data_in}, got);
    end
    m_ready = 1'b0;
    @(negedge clk); #1;
    if (rst) begin m_ready = 1'b1; return; end
    check("m_enable_dropped", m_enable, 0);
    for (int i = 1; (i < BUSY_CYCLES) || model_stuck; i++) begin
      @(negedge clk); #1;
      if (rst) begin m_ready = 1'b1; return; end
    end
    if (rw && !was_stuck && rd_data_q.size() != 0) m_data_out = rd_data_q.pop_front();
    m_ready = 1'b1;
  endtask

  initial begin : master_model
    m_ready    = 1'b1;
    m_data_out = '0;
    forever begin
      @(negedge clk); #1;
      if (rst) m_ready = 1'b1;
      else if (m_enable === 1'b1) serve_txn();
      else m_ready = !model_hold;
    end
  end

  initial begin : rsp_monitor
    logic [DW-1:0] held = '0;
    bit            stalled = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("rsp_valid_held", rsp_valid, 1);
          check("rsp_data_stable", rsp_data, held);
        end
        if (rsp_valid && rsp_ready) begin
          check("rsp_expected", exp_rsp.size() != 0, 1);
          if (exp_rsp.size() != 0) check("rsp_data_order", rsp_data, exp_rsp.pop_front());
        end
        stalled = rsp_valid && !rsp_ready;
        held    = rsp_data;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_rw    = 1'b0;
    cmd_data  = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single write: no response, idle afterwards.
    push_cmd(7'h2A, 1'b0, 8'hA5, acc);
    check("wr_accepted", acc, 1);
    wait_idle(200, "wr");
    check("wr_no_rsp", rsp_valid, 0);

    // Single read with the response held until rsp_ready.
    rsp_ready = 1'b0;
    rd_data_q.push_back(8'h5C);
    exp_rsp.push_back(8'h5C);
    push_cmd(7'h2A, 1'b1, 8'h00, acc);
    wait_rsp(200, "rd");
    check("rd_rsp_data", rsp_data, 8'h5C);
    repeat (5) @(negedge clk);
    check("rd_rsp_still_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rd_rsp_cleared", rsp_valid, 0);
    wait_idle(50, "rd");

    // Fill the FIFO with the master stalled; the fifth push is refused.
    model_hold = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      push_cmd(AW'(i + 1), 1'b0, DW'(8'h10 + i), acc);
      check("full_push_acc", acc, 1);
    end
    @(negedge clk);
    check("full_level", fifo_level, DEPTH);
    check("full_cmd_ready", cmd_ready, 0);
    push_cmd(7'h05, 1'b0, 8'h14, acc);
    check("full_5th_rejected", acc, 0);
    check("full_level_after_5th", fifo_level, DEPTH);
    model_hold = 1'b0;
    wait_idle(400, "drain");
    check("drain_all_issued", exp_cmd.size(), 0);

    // Two reads with rsp_ready low: second stalls in CAPTURE.
    @(negedge clk);
    rsp_ready = 1'b0;
    rd_data_q.push_back(8'h11);
    rd_data_q.push_back(8'h22);
    exp_rsp.push_back(8'h11);
    exp_rsp.push_back(8'h22);
    push_cmd(7'h30, 1'b1, 8'h00, acc);
    push_cmd(7'h31, 1'b1, 8'h00, acc);
    wait_rsp(200, "b2b");
    repeat (150) @(negedge clk);
    check("b2b_first_held", rsp_data, 8'h11);
    check("b2b_valid_held", rsp_valid, 1);
    check("b2b_capture_stall_busy", busy, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("b2b_second_valid", rsp_valid, 1);
    check("b2b_second_data", rsp_data, 8'h22);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("b2b_drained", rsp_valid, 0);
    wait_idle(50, "b2b");

`ifdef I2C_SEQ_TIMEOUT_EN
    // Master never returns: timeout after TO cycles, no response emitted.
    model_stuck = 1'b1;
    push_cmd(7'h40, 1'b1, 8'h00, acc);
    n = 0;
    while (m_enable !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("to_enable_seen", m_enable, 1);
    n = 0;
    while (err_timeout !== 1'b1 && n < 4 * TO) begin @(negedge clk); n++; end
    check("to_cycles", n, TO);
    check("to_m_enable_low", m_enable, 0);
    check("to_back_idle", busy, 0);
    push_cmd(7'h41, 1'b0, 8'h77, acc);
    model_stuck = 1'b0;
    wait_idle(200, "to_next");
    check("to_next_issued", exp_cmd.size(), 0);
    check("to_sticky", err_timeout, 1);
`endif

    // Reset while BUSY with two commands queued.
    rsp_ready = 1'b1;
    push_cmd(7'h50, 1'b0, 8'h01, acc);
    push_cmd(7'h51, 1'b0, 8'h02, acc);
    push_cmd(7'h52, 1'b1, 8'h03, acc);
    n = 0;
    while (!(m_enable === 1'b0 && m_ready === 1'b0 && busy === 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_reached_busy", (m_enable === 1'b0) && (m_ready === 1'b0), 1);
    check("rst_queued_two", fifo_level, 2);
    rst = 1'b1;
    exp_cmd.delete();
    exp_rsp.delete();
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("post_rst_idle", busy, 0);
    check("post_rst_no_issue", m_enable, 0);
    check("post_rst_no_rsp", rsp_valid, 0);

    check("end_rsp_all_delivered", exp_rsp.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_i2c_cmd_sequencer
